// File: rtl/core_debug_controller.sv
// Run-control and debug sequencer for the single-cycle core: halt/run/step,
// PC breakpoint, retired-instruction counter and a streaming register dump.
module core_debug_controller #(
    parameter int unsigned NUM_REGS = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        run_req,
    input  logic        halt_req,
    input  logic        step_req,
    input  logic        dump_req,
    input  logic        bp_en,
    input  logic [31:0] bp_addr,
    input  logic [31:0] PC,
    input  logic [31:0] Debug_out,
    input  logic [4:0]  dbg_sel_in,
    output logic        core_en,
    output logic [4:0]  Debug_source_select,
    output logic [31:0] dump_data,
    output logic [4:0]  dump_idx,
    output logic        dump_valid,
    input  logic        dump_ready,
    output logic        dump_done,
    output logic        halted,
    output logic        bp_hit,
    output logic [31:0] instr_count
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned IDX_W  = 5;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);

    typedef enum logic [2:0] {
        HALTED    = 3'd0,
        RUNNING   = 3'd1,
        STEP      = 3'd2,
        DUMP_SEL  = 3'd3,
        DUMP_WAIT = 3'd4
    } state_e;

    state_e              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic                resume_q, resume_d;
    logic                bp_hit_q, bp_hit_d;
    logic                halted_q, halted_d;
    logic                dump_valid_q, dump_valid_d;
    logic                dump_done_q, dump_done_d;
    logic [DATA_W-1:0]   dump_data_q, dump_data_d;
    logic [IDX_W-1:0]    dump_idx_q, dump_idx_d;
    logic [DATA_W-1:0]   instr_count_q, instr_count_d;
    logic                bp_match;

    // Breakpoint is suppressed on the first running cycle so a resume executes the bp instruction
    assign bp_match = bp_en && (PC == bp_addr) && !resume_q;

    // Core clock enable: one cycle in STEP, free-running in RUNNING unless halted or at breakpoint
    always_comb begin
        core_en = 1'b0;
        case (state_q)
            STEP:    core_en = 1'b1;
            RUNNING: core_en = !halt_req && !bp_match;
            default: core_en = 1'b0;
        endcase
    end

    // Debug read select: dump walker owns the port while dumping, host otherwise
    always_comb begin
        Debug_source_select = dbg_sel_in;
        case (state_q)
            DUMP_SEL:  Debug_source_select = idx_q;
            DUMP_WAIT: Debug_source_select = dump_idx_q;
            default:   Debug_source_select = dbg_sel_in;
        endcase
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        resume_d      = resume_q;
        bp_hit_d      = bp_hit_q;
        dump_valid_d  = dump_valid_q;
        dump_done_d   = 1'b0;
        dump_data_d   = dump_data_q;
        dump_idx_d    = dump_idx_q;
        instr_count_d = core_en ? instr_count_q + DATA_W'(1) : instr_count_q;

        case (state_q)
            HALTED: begin
                if (dump_req) begin
                    state_d = DUMP_SEL;
                    idx_d   = '0;
                end else if (step_req) begin
                    state_d  = STEP;
                    bp_hit_d = 1'b0;
                end else if (run_req) begin
                    state_d  = RUNNING;
                    resume_d = 1'b1;
                    bp_hit_d = 1'b0;
                end
            end
            STEP: begin
                state_d = HALTED;
            end
            RUNNING: begin
                resume_d = 1'b0;
                if (halt_req) begin
                    state_d = HALTED;
                end else if (bp_match) begin
                    state_d  = HALTED;
                    bp_hit_d = 1'b1;
                end
            end
            DUMP_SEL: begin
                dump_data_d  = Debug_out;
                dump_idx_d   = idx_q;
                dump_valid_d = 1'b1;
                state_d      = DUMP_WAIT;
            end
            DUMP_WAIT: begin
                if (dump_valid_q && dump_ready) begin
                    dump_valid_d = 1'b0;
                    if (idx_q == LAST_IDX) begin
                        dump_done_d = 1'b1;
                        state_d     = HALTED;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = DUMP_SEL;
                    end
                end
            end
            default: begin
                state_d = HALTED;
            end
        endcase

        halted_d = (state_d == HALTED);
    end

    // State and output registers; reset aborts any run or dump
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= HALTED;
            idx_q         <= '0;
            resume_q      <= 1'b0;
            bp_hit_q      <= 1'b0;
            halted_q      <= 1'b1;
            dump_valid_q  <= 1'b0;
            dump_done_q   <= 1'b0;
            dump_data_q   <= '0;
            dump_idx_q    <= '0;
            instr_count_q <= '0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            resume_q      <= resume_d;
            bp_hit_q      <= bp_hit_d;
            halted_q      <= halted_d;
            dump_valid_q  <= dump_valid_d;
            dump_done_q   <= dump_done_d;
            dump_data_q   <= dump_data_d;
            dump_idx_q    <= dump_idx_d;
            instr_count_q <= instr_count_d;
        end
    end

    assign dump_data   = dump_data_q;
    assign dump_idx    = dump_idx_q;
    assign dump_valid  = dump_valid_q;
    assign dump_done   = dump_done_q;
    assign halted      = halted_q;
    assign bp_hit      = bp_hit_q;
    assign instr_count = instr_count_q;

endmodule

// File: tb/tb_core_debug_controller.sv
// Directed bench for core_debug_controller: step, breakpoint/resume, halt,
// level-held step, full dump, stalled dump and reset during a dump.
module tb_core_debug_controller;

    logic        clk;
    logic        reset;
    logic        run_req, halt_req, step_req, dump_req;
    logic        bp_en;
    logic [31:0] bp_addr;
    logic [31:0] pc;
    logic [31:0] Debug_out;
    logic [4:0]  dbg_sel_in;
    logic        core_en;
    logic [4:0]  Debug_source_select;
    logic [31:0] dump_data;
    logic [4:0]  dump_idx;
    logic        dump_valid;
    logic        dump_ready;
    logic        dump_done;
    logic        halted;
    logic        bp_hit;
    logic [31:0] instr_count;

    int errors = 0;
    int checks = 0;

    core_debug_controller #(.NUM_REGS(32)) dut (
        .clk                 (clk),
        .reset               (reset),
        .run_req             (run_req),
        .halt_req            (halt_req),
        .step_req            (step_req),
        .dump_req            (dump_req),
        .bp_en               (bp_en),
        .bp_addr             (bp_addr),
        .PC                  (pc),
        .Debug_out           (Debug_out),
        .dbg_sel_in          (dbg_sel_in),
        .core_en             (core_en),
        .Debug_source_select (Debug_source_select),
        .dump_data           (dump_data),
        .dump_idx            (dump_idx),
        .dump_valid          (dump_valid),
        .dump_ready          (dump_ready),
        .dump_done           (dump_done),
        .halted              (halted),
        .bp_hit              (bp_hit),
        .instr_count         (instr_count)
    );

    // Core debug read port model: register n reads as 0x1000+n
    assign Debug_out = 32'h1000 + {27'd0, Debug_source_select};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; the core model bumps PC by 4 when it retired an instruction
    task automatic tick();
        logic en;
        en = core_en;
        @(posedge clk);
        #1;
        if (en === 1'b1) pc = pc + 32'd4;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        reset = 1'b0; run_req = 0; halt_req = 0; step_req = 0; dump_req = 0;
        bp_en = 0; bp_addr = 32'h0; pc = 32'h0; dbg_sel_in = 5'd9; dump_ready = 0;
        #12;
        chk("rst_halted", 32'(halted), 32'd1);
        chk("rst_core_en", 32'(core_en), 32'd0);
        chk("rst_bp_hit", 32'(bp_hit), 32'd0);
        chk("rst_dump_valid", 32'(dump_valid), 32'd0);
        chk("rst_dump_done", 32'(dump_done), 32'd0);
        chk("rst_dump_data", dump_data, 32'd0);
        chk("rst_dump_idx", 32'(dump_idx), 32'd0);
        chk("rst_instr_count", instr_count, 32'd0);
        reset = 1'b1;
        tick();
        chk("host_sel", 32'(Debug_source_select), 32'd9);
        chk("host_debug_out", Debug_out, 32'h1009);

        // Single step
        step_req = 1; settle();
        chk("step_en_halted", 32'(core_en), 32'd0);
        tick(); step_req = 0; settle();
        chk("step_en", 32'(core_en), 32'd1);
        chk("step_not_halted", 32'(halted), 32'd0);
        tick(); settle();
        chk("step_en_off", 32'(core_en), 32'd0);
        chk("step_count", instr_count, 32'd1);
        chk("step_halted", 32'(halted), 32'd1);
        tick(); tick();
        chk("step_count_hold", instr_count, 32'd1);

        // Breakpoint at 0x10, running from PC=0
        pc = 32'h0; bp_en = 1; bp_addr = 32'h10;
        run_req = 1; settle();
        tick(); run_req = 0; settle();
        chk("run_en_first", 32'(core_en), 32'd1);
        chk("run_not_halted", 32'(halted), 32'd0);
        tick(); tick(); tick(); tick(); settle();
        chk("bp_pc", pc, 32'h10);
        chk("bp_en_low", 32'(core_en), 32'd0);
        tick();
        chk("bp_hit", 32'(bp_hit), 32'd1);
        chk("bp_halted", 32'(halted), 32'd1);
        chk("bp_count", instr_count, 32'd5);

        // Resume from the breakpoint PC executes it
        run_req = 1; settle();
        tick(); run_req = 0; settle();
        chk("resume_bp_clr", 32'(bp_hit), 32'd0);
        chk("resume_en", 32'(core_en), 32'd1);
        tick(); settle();
        chk("resume_count", instr_count, 32'd6);
        chk("resume_pc", pc, 32'h14);
        chk("resume_still_run", 32'(core_en), 32'd1);
        tick();
        chk("run_count", instr_count, 32'd7);

        // Halt: core_en drops in the request cycle
        halt_req = 1; settle();
        chk("halt_en_same_cycle", 32'(core_en), 32'd0);
        tick(); halt_req = 0; bp_en = 0; settle();
        chk("halt_halted", 32'(halted), 32'd1);
        tick(); tick(); tick();
        chk("halt_count_frozen", instr_count, 32'd7);

        // Level-held step: one instruction every 2 cycles
        step_req = 1; settle();
        tick(); tick(); tick(); tick(); step_req = 0; settle();
        chk("held_step_count", instr_count, 32'd9);
        chk("held_step_halted", 32'(halted), 32'd1);

        // Full dump with dump_ready tied high
        dump_ready = 1; dump_req = 1; settle();
        tick(); dump_req = 0; settle();
        chk("dump_sel_mux", 32'(Debug_source_select), 32'd0);
        for (int i = 0; i < 32; i++) begin
            tick(); settle();
            chk("dump_valid", 32'(dump_valid), 32'd1);
            chk("dump_idx", 32'(dump_idx), 32'(i));
            chk("dump_data", dump_data, 32'h1000 + 32'(i));
            chk("dump_core_en", 32'(core_en), 32'd0);
            chk("dump_done_early", 32'(dump_done), 32'd0);
            tick();
        end
        chk("dump_done_pulse", 32'(dump_done), 32'd1);
        chk("dump_end_halted", 32'(halted), 32'd1);
        chk("dump_end_valid", 32'(dump_valid), 32'd0);
        tick();
        chk("dump_done_once", 32'(dump_done), 32'd0);
        chk("dump_count_frozen", instr_count, 32'd9);

        // Stalled dump at idx 3 with ignored run/halt requests
        dump_req = 1; settle();
        tick(); dump_req = 0;
        for (int i = 0; i < 3; i++) begin
            tick(); tick();
        end
        tick(); dump_ready = 0;
        for (int c = 0; c < 5; c++) begin
            run_req  = (c == 1);
            halt_req = (c == 3);
            settle();
            chk("stall_core_en", 32'(core_en), 32'd0);
            tick();
            chk("stall_valid", 32'(dump_valid), 32'd1);
            chk("stall_idx", 32'(dump_idx), 32'd3);
            chk("stall_data", dump_data, 32'h1003);
            chk("stall_not_halted", 32'(halted), 32'd0);
        end
        run_req = 0; halt_req = 0; dump_ready = 1; settle();
        tick();
        chk("stall_release_valid", 32'(dump_valid), 32'd0);
        tick();
        chk("after_stall_idx", 32'(dump_idx), 32'd4);
        chk("after_stall_data", dump_data, 32'h1004);
        tick(); tick(); tick(); tick(); tick();
        dump_ready = 0;
        tick();
        chk("pre_rst_idx", 32'(dump_idx), 32'd7);
        chk("pre_rst_valid", 32'(dump_valid), 32'd1);

        // Reset during DUMP_WAIT aborts immediately
        reset = 0; settle();
        chk("mid_rst_valid", 32'(dump_valid), 32'd0);
        chk("mid_rst_halted", 32'(halted), 32'd1);
        chk("mid_rst_count", instr_count, 32'd0);
        chk("mid_rst_idx", 32'(dump_idx), 32'd0);
        tick();
        reset = 1; dump_ready = 1; dump_req = 1; settle();
        tick(); dump_req = 0;
        tick();
        chk("restart_idx", 32'(dump_idx), 32'd0);
        chk("restart_data", dump_data, 32'h1000);
        chk("restart_valid", 32'(dump_valid), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global watchdog so the run always terminates
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
